// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO slot initiator.
//   DATA_W      - slot data bus width
//   REG_ADDR_W  - register address width within a slot
//   state_e     - request sequencing states of mmio_master
package mmio_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    ERR,
    DONE
  } state_e;

endpackage

// File: rtl/mmio_slot_decode.sv
// Combinational slot decode for the MMIO initiator.
//   slot  - slot index taken from the request address
//   cs    - one-hot select, all zero when the index is out of range
//   valid - index addresses an existing slot
module mmio_slot_decode #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_W    = 3
) (
  input  logic [SLOT_W-1:0]    slot,
  output logic [NUM_SLOTS-1:0] cs,
  output logic                 valid
);

  always_comb begin
    cs = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (slot == SLOT_W'(i)) cs[i] = 1'b1;
    end
  end

  // Indices beyond NUM_SLOTS match no cs bit.
  assign valid = |cs;

endmodule

// File: rtl/mmio_master.sv
// MMIO slot initiator: takes one core-side request at a time, strobes the addressed slot
// for a single cycle, and returns a one-cycle response pulse.
//   clk, reset            - clock, synchronous active-high reset
//   req_valid/req_ready   - request handshake; req_write, req_addr {slot, reg}, req_wdata
//   rsp_valid             - one-cycle response pulse with rsp_rdata and rsp_err
//   cs, read, write       - slot select and single-cycle strobes
//   reg_addr, wr_data     - register address and write data towards the slot
//   rd_data_bus           - concatenated slot read data, slot i at [32i+31:32i]
module mmio_master
  import mmio_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_W    = 3,
  parameter int unsigned RD_LAT    = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [SLOT_W+REG_ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]              req_wdata,
  output logic                           rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           rsp_err,
  output logic [NUM_SLOTS-1:0]           cs,
  output logic                           read,
  output logic                           write,
  output logic [REG_ADDR_W-1:0]          reg_addr,
  output logic [DATA_W-1:0]              wr_data,
  input  logic [NUM_SLOTS*DATA_W-1:0]    rd_data_bus
);

  localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_e                 state;
  logic                   lat_write;
  logic [SLOT_W-1:0]      lat_slot;
  logic [1:0]             wait_cnt;
  logic [NUM_SLOTS-1:0]   dec_cs;
  logic                   dec_valid;
  logic [DATA_W-1:0]      slot_rdata;

  mmio_slot_decode #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_decode (
    .slot  (req_addr[SLOT_W+REG_ADDR_W-1:REG_ADDR_W]),
    .cs    (dec_cs),
    .valid (dec_valid)
  );

  // Read data of the latched slot; only sampled for in-range reads.
  always_comb begin
    slot_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (lat_slot == SLOT_W'(i)) slot_rdata = rd_data_bus[i*DATA_W +: DATA_W];
    end
  end

  // DONE also accepts, so back-to-back writes issue every two cycles.
  assign req_ready = ((state == IDLE) || (state == DONE)) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_slot  <= '0;
      wait_cnt  <= '0;
      cs        <= '0;
      read      <= 1'b0;
      write     <= 1'b0;
      reg_addr  <= '0;
      wr_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      read      <= 1'b0;
      write     <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          cs        <= '0;
          reg_addr  <= '0;
          wr_data   <= '0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
          if (req_valid) begin
            lat_write <= req_write;
            lat_slot  <= req_addr[SLOT_W+REG_ADDR_W-1:REG_ADDR_W];
            if (dec_valid) begin
              state    <= ACCESS;
              cs       <= dec_cs;
              read     <= !req_write;
              write    <= req_write;
              reg_addr <= req_addr[REG_ADDR_W-1:0];
              wr_data  <= req_wdata;
            end else begin
              state <= ERR;
            end
          end
        end
        ACCESS: begin
          if (lat_write || (RD_LAT == 0)) begin
            state     <= DONE;
            cs        <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= lat_write ? '0 : slot_rdata;
          end else begin
            // cs and reg_addr stay up while the slot produces data.
            state    <= WAIT;
            wait_cnt <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            state     <= DONE;
            cs        <= '0;
            rsp_valid <= 1'b1;
            rsp_rdata <= slot_rdata;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ERR: begin
          state     <= DONE;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
